// File: rtl/exu_disp.sv
// exu_disp: dispatch stage with OITF-based long-op tracking, hazard stall and illegal-instruction handling
//   clk, rst_n          : clock, synchronous active-low reset
//   i_valid/i_ready     : decoded instruction handshake (i_info group selects the issue port)
//   i_rs*/i_rd*         : register usage enables and indices for hazard checks
//   i_illegal, i_flush  : illegal instruction flag, dispatch suppression
//   o_alu/md/agu_valid  : issue valids with matching readies; o_itag = OITF slot of an issued long op
//   i_lwb_valid/o_lwb_* : in-order long-op writeback retiring the OITF head
//   o_excp_valid        : illegal-instruction exception request, i_excp_ready acknowledges
//   o_oitf_empty        : no long ops outstanding
`ifndef DECINFO_WIDTH
`define DECINFO_WIDTH 32
`endif
`ifndef DECINFO_GRP
`define DECINFO_GRP 2:0
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif
module exu_disp #(
  parameter int OITF_DEPTH = 2
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   i_valid,
  output logic                                   i_ready,
  input  logic [`DECINFO_WIDTH-1:0]              i_info,
  input  logic                                   i_rs1en,
  input  logic                                   i_rs2en,
  input  logic                                   i_rdwen,
  input  logic [`RFIDX_WIDTH-1:0]                i_rs1idx,
  input  logic [`RFIDX_WIDTH-1:0]                i_rs2idx,
  input  logic [`RFIDX_WIDTH-1:0]                i_rdidx,
  input  logic                                   i_illegal,
  input  logic                                   i_flush,
  output logic                                   o_alu_valid,
  input  logic                                   i_alu_ready,
  output logic                                   o_md_valid,
  input  logic                                   i_md_ready,
  output logic                                   o_agu_valid,
  input  logic                                   i_agu_ready,
  output logic [$clog2(OITF_DEPTH)-1:0]          o_itag,
  input  logic                                   i_lwb_valid,
  output logic                                   o_lwb_ready,
  output logic [`RFIDX_WIDTH-1:0]                o_lwb_rdidx,
  output logic                                   o_lwb_rdwen,
  output logic                                   o_excp_valid,
  input  logic                                   i_excp_ready,
  output logic                                   o_oitf_empty
);
  localparam int AW = $clog2(OITF_DEPTH);
  localparam logic [2:0] GRP_AGU = 3'd1;
  localparam logic [2:0] GRP_MULDIV = 3'd4;
  typedef enum logic [1:0] {RUN, DRAIN, EXCP} state_t;
  state_t state;
  logic [AW:0] wptr, rptr, cnt;
  logic [`RFIDX_WIDTH-1:0] rd_mem [OITF_DEPTH];
  logic [OITF_DEPTH-1:0] wen_mem, live, hit;
  logic [2:0] grp;
  logic is_md, is_agu, is_long, hazard, empty, full, go, tready, push, pop;
  logic unused;
  assign unused = ^i_info;
  assign grp = i_info[`DECINFO_GRP];
  assign is_md = grp == GRP_MULDIV;
  assign is_agu = grp == GRP_AGU;
  assign is_long = is_md | is_agu;
  assign cnt = wptr - rptr;
  assign empty = wptr == rptr;
  assign full = (wptr[AW-1:0] == rptr[AW-1:0]) & (wptr[AW] != rptr[AW]);
  // An entry is live when its distance from the head is below the occupancy.
  for (genvar k = 0; k < OITF_DEPTH; k++) begin : g_ent
    logic [AW-1:0] off;
    assign off = AW'(k) - rptr[AW-1:0];
    assign live[k] = {1'b0, off} < cnt;
    assign hit[k] = live[k] & wen_mem[k] & ((i_rs1en & (i_rs1idx == rd_mem[k])) |
                    (i_rs2en & (i_rs2idx == rd_mem[k])) | (i_rdwen & (i_rdidx == rd_mem[k])));
  end
  assign hazard = |hit;
  assign go = rst_n & (state == RUN) & i_valid & ~i_illegal & ~i_flush & ~hazard & (~is_long | ~full);
  assign tready = is_md ? i_md_ready : is_agu ? i_agu_ready : i_alu_ready;
  assign o_alu_valid = go & ~is_long;
  assign o_md_valid = go & is_md;
  assign o_agu_valid = go & is_agu;
  // In EXCP the acknowledge consumes the held illegal instruction; a flush cancels it instead.
  assign i_ready = rst_n & ((state == EXCP) ? i_excp_ready & ~i_flush : go & tready);
  assign push = go & tready & is_long;
  assign pop = i_lwb_valid & ~empty;
  assign o_itag = wptr[AW-1:0];
  assign o_lwb_ready = ~empty;
  assign o_lwb_rdidx = rd_mem[rptr[AW-1:0]];
  assign o_lwb_rdwen = wen_mem[rptr[AW-1:0]];
  assign o_excp_valid = state == EXCP;
  assign o_oitf_empty = empty;
  always_ff @(posedge clk)
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      state <= RUN;
    end else begin
      if (push) wptr <= wptr + (AW+1)'(1);
      if (pop) rptr <= rptr + (AW+1)'(1);
      state <= (state == RUN) ? ((i_valid & i_illegal & ~i_flush) ? (empty ? EXCP : DRAIN) : RUN)
             : i_flush ? RUN
             : (state == DRAIN) ? (empty ? EXCP : DRAIN)
             : (i_excp_ready ? RUN : EXCP);
    end
  always_ff @(posedge clk)
    if (push) begin
      rd_mem[wptr[AW-1:0]] <= i_rdidx;
      wen_mem[wptr[AW-1:0]] <= i_rdwen;
    end
endmodule

// File: tb/tb_exu_disp.sv
// tb_exu_disp: scenario tasks with a writeback scoreboard for exu_disp
`ifndef DECINFO_WIDTH
`define DECINFO_WIDTH 32
`endif
`ifndef DECINFO_GRP
`define DECINFO_GRP 2:0
`endif
`ifndef RFIDX_WIDTH
`define RFIDX_WIDTH 5
`endif
module tb_exu_disp;
  localparam logic [2:0] ALU = 3'd0, AGU = 3'd1, BJP = 3'd2, MULDIV = 3'd4;
  logic clk, rst_n, i_valid, i_ready, i_rs1en, i_rs2en, i_rdwen, i_illegal, i_flush;
  logic [`DECINFO_WIDTH-1:0] i_info;
  logic [4:0] i_rs1idx, i_rs2idx, i_rdidx, o_lwb_rdidx;
  logic o_alu_valid, i_alu_ready, o_md_valid, i_md_ready, o_agu_valid, i_agu_ready;
  logic [0:0] o_itag, exp_tag;
  logic i_lwb_valid, o_lwb_ready, o_lwb_rdwen, o_excp_valid, i_excp_ready, o_oitf_empty;
  logic [5:0] sb[$];
  int n_pass, n_total;
  exu_disp #(.OITF_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .i_valid(i_valid), .i_ready(i_ready), .i_info(i_info),
    .i_rs1en(i_rs1en), .i_rs2en(i_rs2en), .i_rdwen(i_rdwen),
    .i_rs1idx(i_rs1idx), .i_rs2idx(i_rs2idx), .i_rdidx(i_rdidx),
    .i_illegal(i_illegal), .i_flush(i_flush),
    .o_alu_valid(o_alu_valid), .i_alu_ready(i_alu_ready),
    .o_md_valid(o_md_valid), .i_md_ready(i_md_ready),
    .o_agu_valid(o_agu_valid), .i_agu_ready(i_agu_ready), .o_itag(o_itag),
    .i_lwb_valid(i_lwb_valid), .o_lwb_ready(o_lwb_ready), .o_lwb_rdidx(o_lwb_rdidx),
    .o_lwb_rdwen(o_lwb_rdwen), .o_excp_valid(o_excp_valid), .i_excp_ready(i_excp_ready),
    .o_oitf_empty(o_oitf_empty)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic v, input logic [2:0] g, input logic r1e, input logic [4:0] r1,
                       input logic r2e, input logic [4:0] r2, input logic rde, input logic [4:0] rd,
                       input logic ill);
    i_valid = v;
    i_info = '0;
    i_info[`DECINFO_GRP] = g;
    i_rs1en = r1e; i_rs1idx = r1;
    i_rs2en = r2e; i_rs2idx = r2;
    i_rdwen = rde; i_rdidx = rd;
    i_illegal = ill;
  endtask
  task automatic idle;
    drive(0, ALU, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset;
    rst_n = 0;
    idle();
    tick();
    rst_n = 1;
    sb.delete();
    exp_tag = 0;
  endtask
  task automatic wb_check;
    logic [5:0] e;
    n_total++;
    if (sb.size() == 0) $display("FAIL wb_sb: unexpected writeback rd=%0d", o_lwb_rdidx);
    else begin
      e = sb.pop_front();
      if ({o_lwb_ready, o_lwb_rdwen, o_lwb_rdidx} !== {1'b1, e})
        $display("FAIL wb_head got rdy=%b wen=%b rd=%0d exp rdy=1 wen=%b rd=%0d",
                 o_lwb_ready, o_lwb_rdwen, o_lwb_rdidx, e[5], e[4:0]);
      else n_pass++;
    end
  endtask
  task automatic do_wb;
    i_lwb_valid = 1;
    #1;
    wb_check();
    tick();
    i_lwb_valid = 0;
  endtask
  task automatic issue_long(input logic [2:0] g, input logic rde, input logic [4:0] rd, input string nm);
    drive(1, g, 1, 5'd1, 1, 5'd2, rde, rd, 0);
    #1;
    n_total++;
    if ({o_alu_valid, o_md_valid, o_agu_valid, i_ready} !== {1'b0, g == MULDIV, g == AGU, 1'b1} || o_itag !== exp_tag)
      $display("FAIL %s got alu/md/agu/rdy=%b%b%b%b tag=%0d exp tag=%0d", nm,
               o_alu_valid, o_md_valid, o_agu_valid, i_ready, o_itag, exp_tag);
    else n_pass++;
    sb.push_back({rde, rd});
    exp_tag++;
    tick();
    idle();
  endtask
  task automatic test_reset;
    rst_n = 0;
    drive(1, ALU, 1, 5'd1, 1, 5'd2, 1, 5'd3, 0);
    #1;
    n_total++;
    if ({o_alu_valid, o_md_valid, o_agu_valid, i_ready} !== 4'b0000)
      $display("FAIL rst_gate got=%b%b%b%b exp=0000", o_alu_valid, o_md_valid, o_agu_valid, i_ready);
    else n_pass++;
    tick();
    n_total++;
    if ({o_oitf_empty, o_lwb_ready, o_excp_valid} !== 3'b100)
      $display("FAIL rst_state got=%b%b%b exp=100", o_oitf_empty, o_lwb_ready, o_excp_valid);
    else n_pass++;
    rst_n = 1;
    idle();
    sb.delete();
    exp_tag = 0;
  endtask
  task automatic test_alu;
    drive(1, ALU, 1, 5'd1, 1, 5'd2, 1, 5'd3, 0);
    #1;
    n_total++;
    if ({o_alu_valid, o_md_valid, o_agu_valid, i_ready} !== 4'b1001)
      $display("FAIL alu_issue got=%b%b%b%b exp=1001", o_alu_valid, o_md_valid, o_agu_valid, i_ready);
    else n_pass++;
    tick();
    drive(1, BJP, 1, 5'd1, 1, 5'd2, 0, 5'd0, 0);
    #1;
    n_total++;
    if ({o_alu_valid, i_ready} !== 2'b11) $display("FAIL bjp_issue got=%b%b exp=11", o_alu_valid, i_ready);
    else n_pass++;
    tick();
    i_alu_ready = 0;
    drive(1, ALU, 1, 5'd1, 0, 5'd0, 1, 5'd4, 0);
    #1;
    n_total++;
    if ({o_alu_valid, i_ready} !== 2'b10) $display("FAIL alu_notready got=%b%b exp=10", o_alu_valid, i_ready);
    else n_pass++;
    i_alu_ready = 1;
    tick();
    idle();
    #1;
    n_total++;
    if (o_oitf_empty !== 1'b1) $display("FAIL alu_empty got=%b exp=1", o_oitf_empty);
    else n_pass++;
  endtask
  task automatic test_raw;
    issue_long(MULDIV, 1, 5'd5, "raw_mul");
    drive(1, ALU, 1, 5'd5, 0, 5'd0, 1, 5'd6, 0);
    repeat (3) begin
      #1;
      n_total++;
      if ({o_alu_valid, i_ready, o_lwb_ready} !== 3'b001)
        $display("FAIL raw_block got val/rdy/lwb=%b%b%b exp=001", o_alu_valid, i_ready, o_lwb_ready);
      else n_pass++;
      tick();
    end
    i_lwb_valid = 1;
    #1;
    wb_check();
    n_total++;
    if (i_ready !== 1'b0) $display("FAIL raw_retire_cycle got=%b exp=0", i_ready);
    else n_pass++;
    tick();
    i_lwb_valid = 0;
    #1;
    n_total++;
    if ({o_alu_valid, i_ready} !== 2'b11) $display("FAIL raw_release got=%b%b exp=11", o_alu_valid, i_ready);
    else n_pass++;
    tick();
    idle();
  endtask
  task automatic test_hazard;
    issue_long(MULDIV, 1, 5'd9, "haz_mul");
    drive(1, ALU, 0, 5'd0, 0, 5'd0, 1, 5'd9, 0);
    #1;
    n_total++;
    if (i_ready !== 1'b0) $display("FAIL waw got=%b exp=0", i_ready);
    else n_pass++;
    drive(1, ALU, 0, 5'd0, 1, 5'd9, 0, 5'd0, 0);
    #1;
    n_total++;
    if (i_ready !== 1'b0) $display("FAIL raw_rs2 got=%b exp=0", i_ready);
    else n_pass++;
    drive(1, ALU, 0, 5'd9, 0, 5'd9, 0, 5'd9, 0);
    #1;
    n_total++;
    if ({o_alu_valid, i_ready} !== 2'b11) $display("FAIL no_enable got=%b%b exp=11", o_alu_valid, i_ready);
    else n_pass++;
    tick();
    idle();
    do_wb();
    issue_long(AGU, 0, 5'd4, "haz_store");
    drive(1, ALU, 1, 5'd4, 0, 5'd0, 1, 5'd4, 0);
    #1;
    n_total++;
    if (i_ready !== 1'b1) $display("FAIL rdwen0_nohaz got=%b exp=1", i_ready);
    else n_pass++;
    tick();
    idle();
    do_wb();
    issue_long(AGU, 1, 5'd0, "haz_x0ld");
    drive(1, ALU, 1, 5'd0, 0, 5'd0, 0, 5'd0, 0);
    #1;
    n_total++;
    if (i_ready !== 1'b0) $display("FAIL x0_haz got=%b exp=0", i_ready);
    else n_pass++;
    idle();
    do_wb();
    #1;
    n_total++;
    if (o_oitf_empty !== 1'b1) $display("FAIL haz_empty got=%b exp=1", o_oitf_empty);
    else n_pass++;
  endtask
  task automatic test_full;
    do_reset();
    issue_long(AGU, 1, 5'd6, "full_ld0");
    issue_long(AGU, 1, 5'd7, "full_ld1");
    drive(1, AGU, 1, 5'd10, 0, 5'd0, 1, 5'd8, 0);
    repeat (2) begin
      #1;
      n_total++;
      if ({o_agu_valid, i_ready} !== 2'b00) $display("FAIL full_block got=%b%b exp=00", o_agu_valid, i_ready);
      else n_pass++;
      tick();
    end
    i_lwb_valid = 1;
    #1;
    wb_check();
    n_total++;
    if (i_ready !== 1'b0) $display("FAIL full_pop_cycle got=%b exp=0", i_ready);
    else n_pass++;
    tick();
    i_lwb_valid = 0;
    #1;
    n_total++;
    if ({o_agu_valid, i_ready} !== 2'b11 || o_itag !== exp_tag)
      $display("FAIL full_release got=%b%b tag=%0d exp=11 tag=%0d", o_agu_valid, i_ready, o_itag, exp_tag);
    else n_pass++;
    sb.push_back({1'b1, 5'd8});
    exp_tag++;
    tick();
    idle();
    do_wb();
    do_wb();
    #1;
    n_total++;
    if (o_oitf_empty !== 1'b1) $display("FAIL full_empty got=%b exp=1", o_oitf_empty);
    else n_pass++;
  endtask
  task automatic test_push_pop;
    issue_long(MULDIV, 1, 5'd11, "pp_mul0");
    drive(1, MULDIV, 1, 5'd1, 1, 5'd2, 1, 5'd12, 0);
    i_lwb_valid = 1;
    #1;
    wb_check();
    n_total++;
    if ({o_md_valid, i_ready} !== 2'b11 || o_itag !== exp_tag)
      $display("FAIL pp_issue got=%b%b tag=%0d exp=11 tag=%0d", o_md_valid, i_ready, o_itag, exp_tag);
    else n_pass++;
    sb.push_back({1'b1, 5'd12});
    exp_tag++;
    tick();
    i_lwb_valid = 0;
    idle();
    #1;
    n_total++;
    if ({o_oitf_empty, o_lwb_ready} !== 2'b01) $display("FAIL pp_occ got=%b%b exp=01", o_oitf_empty, o_lwb_ready);
    else n_pass++;
    do_wb();
  endtask
  task automatic test_illegal;
    int n;
    issue_long(MULDIV, 1, 5'd13, "ill_mul");
    i_excp_ready = 0;
    drive(1, ALU, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1);
    #1;
    n_total++;
    if ({o_alu_valid, i_ready} !== 2'b00) $display("FAIL ill_run got=%b%b exp=00", o_alu_valid, i_ready);
    else n_pass++;
    tick();
    repeat (2) begin
      #1;
      n_total++;
      if ({o_alu_valid, i_ready, o_excp_valid} !== 3'b000)
        $display("FAIL drain got=%b%b%b exp=000", o_alu_valid, i_ready, o_excp_valid);
      else n_pass++;
      tick();
    end
    do_wb();
    n = 0;
    while (o_excp_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    n_total++;
    if (o_excp_valid !== 1'b1 || i_ready !== 1'b0)
      $display("FAIL excp_reach got excp=%b rdy=%b exp excp=1 rdy=0", o_excp_valid, i_ready);
    else n_pass++;
    i_excp_ready = 1;
    #1;
    n_total++;
    if (i_ready !== 1'b1) $display("FAIL excp_consume got=%b exp=1", i_ready);
    else n_pass++;
    tick();
    i_excp_ready = 0;
    drive(1, ALU, 1, 5'd1, 0, 5'd0, 1, 5'd2, 0);
    #1;
    n_total++;
    if ({o_excp_valid, o_alu_valid, i_ready} !== 3'b011)
      $display("FAIL excp_exit got=%b%b%b exp=011", o_excp_valid, o_alu_valid, i_ready);
    else n_pass++;
    tick();
    idle();
  endtask
  task automatic test_excp_flush;
    drive(1, BJP, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1);
    tick();
    #1;
    n_total++;
    if (o_excp_valid !== 1'b1) $display("FAIL ill_direct got=%b exp=1", o_excp_valid);
    else n_pass++;
    i_flush = 1;
    i_excp_ready = 1;
    #1;
    n_total++;
    if (i_ready !== 1'b0) $display("FAIL excp_flush_rdy got=%b exp=0", i_ready);
    else n_pass++;
    tick();
    i_flush = 0;
    i_excp_ready = 0;
    drive(1, ALU, 1, 5'd1, 0, 5'd0, 1, 5'd2, 0);
    #1;
    n_total++;
    if ({o_excp_valid, o_alu_valid, i_ready} !== 3'b011)
      $display("FAIL excp_flush_run got=%b%b%b exp=011", o_excp_valid, o_alu_valid, i_ready);
    else n_pass++;
    tick();
    idle();
  endtask
  task automatic test_reset_mid;
    issue_long(AGU, 1, 5'd20, "rm_ld0");
    issue_long(AGU, 1, 5'd21, "rm_ld1");
    drive(1, ALU, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1);
    tick();
    tick();
    rst_n = 0;
    tick();
    rst_n = 1;
    idle();
    sb.delete();
    exp_tag = 0;
    #1;
    n_total++;
    if ({o_oitf_empty, o_excp_valid, o_lwb_ready} !== 3'b100)
      $display("FAIL rst_mid got=%b%b%b exp=100", o_oitf_empty, o_excp_valid, o_lwb_ready);
    else n_pass++;
    drive(1, BJP, 0, 5'd0, 0, 5'd0, 0, 5'd0, 1);
    tick();
    #1;
    n_total++;
    if (o_excp_valid !== 1'b1) $display("FAIL rst_excp_pre got=%b exp=1", o_excp_valid);
    else n_pass++;
    rst_n = 0;
    tick();
    rst_n = 1;
    drive(1, ALU, 1, 5'd20, 0, 5'd0, 1, 5'd21, 0);
    #1;
    n_total++;
    if ({o_excp_valid, o_oitf_empty, o_alu_valid, i_ready} !== 4'b0111)
      $display("FAIL rst_excp got=%b%b%b%b exp=0111", o_excp_valid, o_oitf_empty, o_alu_valid, i_ready);
    else n_pass++;
    tick();
    idle();
  endtask
  task automatic test_flush;
    drive(1, ALU, 1, 5'd1, 1, 5'd2, 1, 5'd3, 0);
    i_flush = 1;
    #1;
    n_total++;
    if ({o_alu_valid, i_ready} !== 2'b00) $display("FAIL flush_block got=%b%b exp=00", o_alu_valid, i_ready);
    else n_pass++;
    tick();
    i_flush = 0;
    #1;
    n_total++;
    if ({o_alu_valid, i_ready} !== 2'b11) $display("FAIL flush_release got=%b%b exp=11", o_alu_valid, i_ready);
    else n_pass++;
    tick();
    drive(1, MULDIV, 1, 5'd1, 1, 5'd2, 1, 5'd7, 0);
    i_flush = 1;
    tick();
    i_flush = 0;
    idle();
    #1;
    n_total++;
    if (o_oitf_empty !== 1'b1) $display("FAIL flush_nopush got=%b exp=1", o_oitf_empty);
    else n_pass++;
    issue_long(MULDIV, 1, 5'd7, "flush_mul");
    i_flush = 1;
    do_wb();
    i_flush = 0;
  endtask
  initial begin
    n_pass = 0;
    n_total = 0;
    exp_tag = 0;
    rst_n = 0;
    i_flush = 0;
    i_lwb_valid = 0;
    i_excp_ready = 0;
    i_alu_ready = 1;
    i_md_ready = 1;
    i_agu_ready = 1;
    idle();
    tick();
    test_reset();
    test_alu();
    test_raw();
    test_hazard();
    test_full();
    test_push_pop();
    test_illegal();
    test_excp_flush();
    test_reset_mid();
    test_flush();
    n_total++;
    if (sb.size() != 0) $display("FAIL sb_leftover got=%0d exp=0", sb.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/exu_disp.md
EXU_DISP -- requirements
Module: exu_disp

Interface
REQ-001 SHALL have parameter OITF_DEPTH, default 2, meaning the number of outstanding long-latency ops (power of 2, >=2).
REQ-002 SHALL have ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- i_valid  in  1  decoded instruction valid
- i_ready  out  1  instruction accepted this cycle
- i_info  in  `DECINFO_WIDTH  decode info bus; group in the `DECINFO_GRP field
- i_rs1en, i_rs2en, i_rdwen  in  1 each  register usage enables
- i_rs1idx, i_rs2idx, i_rdidx  in  `RFIDX_WIDTH each  register indices
- i_illegal  in  1  illegal instruction
- i_flush  in  1  suppress dispatch this cycle
- o_alu_valid  out  1  issue to ALU
- i_alu_ready  in  1
- o_md_valid  out  1  issue to MULDIV
- i_md_ready  in  1
- o_agu_valid  out  1  issue to AGU
- i_agu_ready  in  1
- o_itag  out  log2(OITF_DEPTH)  OITF slot of the issued long op
- i_lwb_valid  in  1  long-op writeback request
- o_lwb_ready  out  1
- o_lwb_rdidx  out  `RFIDX_WIDTH  rd of the OITF head
- o_lwb_rdwen  out  1  head writes rd
- o_excp_valid  out  1  illegal-instruction exception request
- i_excp_ready  in  1
- o_oitf_empty  out  1  no outstanding long ops

Function
REQ-003 SHALL classify by group: ALU and BJP -> ALU port (single-cycle); MULDIV -> MD port (long); AGU -> AGU port (long).
REQ-004 SHALL keep an OITF: a circular FIFO of {rdidx, rdwen}, with read/write pointers carrying an extra wrap bit; empty = pointers equal; full = indices equal and wrap bits differ.
REQ-005 SHALL compute the hazard against every valid OITF entry with rdwen=1:
- RAW: (i_rs1en & rs1idx match) | (i_rs2en & rs2idx match)
- WAW: i_rdwen & rdidx match
- x0 SHALL NOT be exempt.
REQ-006 SHALL base hazard and full checks on registered OITF state only; an entry retiring in the same cycle still counts, giving a 1-cycle penalty.
REQ-007 In RUN, the accept condition SHALL be: i_valid & ~i_illegal & ~i_flush & ~hazard & target_ready & (~long | ~full).
- The target valid SHALL be i_valid & ~i_illegal & ~i_flush & ~hazard & (~long | ~full).
- i_ready SHALL equal the accept condition.
REQ-008 An accepted long op SHALL push {i_rdidx, i_rdwen} at the write pointer, with o_itag = write-pointer index in that cycle.
REQ-009 o_lwb_ready SHALL be ~empty.
- o_lwb_rdidx/o_lwb_rdwen SHALL be the head entry.
- i_lwb_valid & o_lwb_ready SHALL pop the head.
- Writebacks retire in order.
REQ-010 Push and pop SHALL be allowed in the same cycle when not full; occupancy is unchanged.
REQ-011 FSM states: RUN, DRAIN, EXCP.
- RUN: i_valid & i_illegal & ~i_flush -> DRAIN if OITF is non-empty, else EXCP. No port valid is raised.
- DRAIN: all issue valids SHALL be 0 and i_ready SHALL be 0; go to EXCP when OITF is empty.
- EXCP: o_excp_valid=1. On i_excp_ready, assert i_ready for that one cycle to consume the illegal instruction, then go to RUN.
REQ-012 i_flush SHALL force all issue valids and i_ready low in RUN only. In DRAIN/EXCP, i_flush SHALL return the FSM to RUN without raising the exception. Writeback is unaffected.
REQ-013 o_oitf_empty SHALL reflect registered pointer equality.

Reset
REQ-014 When rst_n=0 at a clk edge:
- pointers SHALL become 0 and FSM SHALL become RUN
- o_excp_valid=0, o_lwb_ready=0, o_oitf_empty=1
- all issue valids and i_ready SHALL be 0 in that cycle
REQ-015 Reset SHALL discard all OITF contents mid-operation with no writeback handshake.

Verification
REQ-016 ALU add x3 (rs1=x1, rs2=x2, rdwen), all readies high -> o_alu_valid=1 and i_ready=1 in the same cycle; OITF stays empty.
REQ-017 Dispatch MUL rd=x5, then ADD rs1=x5 -> ADD blocked (i_ready=0) until the cycle after i_lwb_valid with o_lwb_rdidx=5.
REQ-018 Three back-to-back loads (OITF_DEPTH=2), no writeback -> first two issued with o_itag 0,1; third has i_ready=0 until one pop.
REQ-019 Illegal instruction with 1 outstanding MUL -> DRAIN until writeback, then o_excp_valid=1; i_excp_ready=1 -> i_ready=1 for one cycle, back to RUN.
REQ-020 rst_n=0 with OITF full and FSM in EXCP -> next cycle o_oitf_empty=1, o_excp_valid=0, FSM in RUN.
REQ-021 i_flush=1 with a valid ALU op -> o_alu_valid=0 and i_ready=0; the same op is issued in the following cycle once i_flush=0.
